// File: rtl/obc_shift_accumulator_if.sv
// Handshake and data bundle between the OBC shift-accumulator, its sample source,
// the coefficient ROM and the result consumer.
interface obc_shift_accumulator_if #(
    parameter int DATA_W = 32,
    parameter int NBITS  = 16
);
    logic              start;
    logic [NBITS-1:0]  x_a;
    logic [NBITS-1:0]  x_b;
    logic [DATA_W-1:0] init_word;
    logic              s1;
    logic              s2;
    logic [DATA_W-1:0] rom_word;
    logic              busy;
    logic [DATA_W-1:0] y;
    logic              y_valid;
    logic              sat;

    modport master (
        output start, x_a, x_b, init_word, rom_word,
        input  s1, s2, busy, y, y_valid, sat
    );

    modport slave (
        input  start, x_a, x_b, init_word, rom_word,
        output s1, s2, busy, y, y_valid, sat
    );
endinterface

// File: rtl/obc_shift_accumulator.sv
// Bit-serial OBC distributed-arithmetic accumulator: streams two samples LSB-first
// as ROM selects and shift-accumulates the returned words into one saturated term.
module obc_shift_accumulator #(
    parameter int DATA_W = 32,
    parameter int NBITS  = 16
) (
    input logic clk,
    input logic rst,
    obc_shift_accumulator_if.slave bus
);
    localparam int K_W   = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int ACC_W = DATA_W + 2;
    localparam logic [K_W-1:0] K_LAST = K_W'(NBITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [K_W-1:0]           k;
    logic [NBITS-1:0]         sa;
    logic [NBITS-1:0]         sb;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rom_ext;
    logic signed [ACC_W-1:0]  init_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  final_val;
    logic [ACC_W-DATA_W:0]    hi;
    logic                     clip;
    logic [DATA_W-1:0]        y_sat;
    logic [DATA_W-1:0]        y_q;
    logic                     y_valid_q;
    logic                     sat_q;
    logic                     busy_q;

    // The result fits DATA_W only if every bit above the DATA_W sign bit repeats it.
    always_comb begin
        rom_ext   = {{2{bus.rom_word[DATA_W-1]}}, bus.rom_word};
        init_ext  = {{2{bus.init_word[DATA_W-1]}}, bus.init_word};
        sum       = acc + rom_ext;
        final_val = acc - rom_ext;
        hi        = final_val[ACC_W-1:DATA_W-1];
        clip      = (hi != '0) && (hi != '1);
        if (!clip) begin
            y_sat = final_val[DATA_W-1:0];
        end else if (final_val[ACC_W-1]) begin
            y_sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y_sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            acc       <= '0;
            sa        <= '0;
            sb        <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.x_a;
                        sb     <= bus.x_b;
                        acc    <= init_ext;
                        k      <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    // The sign-bit weight is negative, so the last word is subtracted unshifted.
                    if (k == K_LAST) begin
                        y_q       <= y_sat;
                        sat_q     <= clip;
                        y_valid_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        acc <= sum >>> 1;
                        k   <= k + K_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s1      = (state == RUN) & sa[0];
    assign bus.s2      = (state == RUN) & sb[0];
    assign bus.busy    = busy_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sat     = sat_q;
endmodule

// File: tb/tb_obc_shift_accumulator.sv
// Self-checking bench for obc_shift_accumulator: directed scenarios plus randomized
// conversions against a closed-form distributed-arithmetic reference.
module tb_obc_shift_accumulator;
    logic clk;
    logic rst;
    logic [31:0] rom_tbl [4];
    int n_checks;
    int n_fail;

    obc_shift_accumulator_if #(.DATA_W(32), .NBITS(16)) bus ();

    obc_shift_accumulator #(.DATA_W(32), .NBITS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Coefficient ROM model addressed by the serial select pair.
    assign bus.rom_word = rom_tbl[{bus.s1, bus.s2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Nested floor-halvings collapse into one floor division of the weighted word sum.
    function automatic logic [32:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                          input logic [31:0] init);
        longint acc;
        longint fin;
        acc = longint'($signed(init));
        for (int j = 0; j < 15; j++)
            acc += longint'($signed(rom_tbl[{xa[j], xb[j]}])) * (longint'(1) << j);
        acc = acc >>> 15;
        fin = acc - longint'($signed(rom_tbl[{xa[15], xb[15]}]));
        if (fin > 64'sh7FFFFFFF) return {1'b1, 32'h7FFFFFFF};
        if (fin < -64'sh80000000) return {1'b1, 32'h80000000};
        return {1'b0, fin[31:0]};
    endfunction

    task automatic apply_stimulus(input logic [15:0] xa, input logic [15:0] xb, input logic [31:0] init);
        bus.start     = 1'b1;
        bus.x_a       = xa;
        bus.x_b       = xb;
        bus.init_word = init;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.x_a       = 16'($urandom);
        bus.x_b       = 16'($urandom);
        bus.init_word = $urandom;
    endtask

    task automatic run_conv(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                            input logic [31:0] init, input int glitch_k, input bit chain,
                            input logic [15:0] nxa, input logic [15:0] nxb, input logic [31:0] ninit);
        logic [32:0] exp;
        logic [15:0] cap1;
        logic [15:0] cap2;
        int count;
        int busy_cnt;
        exp = model(xa, xb, init);
        count = 0;
        busy_cnt = 0;
        cap1 = '0;
        cap2 = '0;
        while (!bus.y_valid && count < 40) begin
            if (count < 16) begin
                cap1[count] = bus.s1;
                cap2[count] = bus.s2;
            end
            if (bus.busy) busy_cnt++;
            bus.start = (count == glitch_k);
            if (count == glitch_k) begin
                bus.x_a       = ~xa;
                bus.x_b       = xa;
                bus.init_word = ~init;
            end
            @(negedge clk);
            count++;
        end
        bus.start = 1'b0;
        check_output({tag, "_latency"}, 64'(count + 1), 64'(17));
        check_output({tag, "_y"}, 64'(bus.y), 64'(exp[31:0]));
        check_output({tag, "_sat"}, 64'(bus.sat), 64'(exp[32]));
        check_output({tag, "_s1_trace"}, 64'(cap1), 64'(xa));
        check_output({tag, "_s2_trace"}, 64'(cap2), 64'(xb));
        check_output({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(16));
        check_output({tag, "_idle_busy_sel"}, 64'({bus.busy, bus.s1, bus.s2}), 64'(0));
        if (chain) begin
            apply_stimulus(nxa, nxb, ninit);
        end else begin
            @(negedge clk);
            check_output({tag, "_pulse_end"}, 64'(bus.y_valid), 64'(0));
            check_output({tag, "_y_held"}, 64'({bus.sat, bus.y}), 64'(exp));
        end
    endtask

    task automatic set_table_xor();
        rom_tbl[0] = 32'hFFE00000;
        rom_tbl[1] = 32'h00000000;
        rom_tbl[2] = 32'h00000000;
        rom_tbl[3] = 32'hFFE00000;
    endtask

    initial begin
        logic [15:0] xa;
        logic [15:0] xb;
        logic [31:0] init;
        logic [15:0] nxa;
        logic [15:0] nxb;
        logic [31:0] ninit;
        bit chain;
        bit pending;
        int viol;
        n_checks = 0;
        n_fail = 0;
        set_table_xor();
        bus.start = 1'b0;
        bus.x_a = '0;
        bus.x_b = '0;
        bus.init_word = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("reset_outputs", 64'({bus.busy, bus.y_valid, bus.sat, bus.s1, bus.s2}), 64'(0));
        check_output("reset_y", 64'(bus.y), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] basic conversion");
        apply_stimulus(16'h1234, 16'h1234, 32'h0);
        run_conv("basic", 16'h1234, 16'h1234, 32'h0, -1, 1'b0, 16'h0, 16'h0, 32'h0);
        check_output("basic_const", 64'({bus.sat, bus.y}), 64'({1'b0, 32'h00000040}));

        $display("[TB] offset only");
        apply_stimulus(16'h0000, 16'hFFFF, 32'h40000000);
        run_conv("offset", 16'h0000, 16'hFFFF, 32'h40000000, -1, 1'b0, 16'h0, 16'h0, 32'h0);
        check_output("offset_const", 64'({bus.sat, bus.y}), 64'({1'b0, 32'h00008000}));

        $display("[TB] select trace");
        apply_stimulus(16'h0001, 16'h8000, 32'h0);
        run_conv("trace", 16'h0001, 16'h8000, 32'h0, -1, 1'b0, 16'h0, 16'h0, 32'h0);

        $display("[TB] ignored start and back-to-back");
        apply_stimulus(16'h1234, 16'h1234, 32'h0);
        run_conv("glitch", 16'h1234, 16'h1234, 32'h0, 5, 1'b1, 16'h1234, 16'h1234, 32'h0);
        run_conv("b2b", 16'h1234, 16'h1234, 32'h0, -1, 1'b0, 16'h0, 16'h0, 32'h0);
        check_output("b2b_const", 64'(bus.y), 64'(32'h00000040));

        $display("[TB] saturation");
        rom_tbl[0] = 32'h0;
        rom_tbl[1] = 32'h0;
        rom_tbl[2] = 32'h80000000;
        rom_tbl[3] = 32'h0;
        apply_stimulus(16'h8000, 16'h0000, 32'h0);
        run_conv("satur", 16'h8000, 16'h0000, 32'h0, -1, 1'b0, 16'h0, 16'h0, 32'h0);
        check_output("satur_const", 64'({bus.sat, bus.y}), 64'({1'b1, 32'h7FFFFFFF}));

        $display("[TB] reset mid-run");
        set_table_xor();
        apply_stimulus(16'hFFFF, 16'hFFFF, 32'h0);
        repeat (8) @(negedge clk);
        check_output("rst_pre_active", 64'({bus.busy, bus.s1, bus.s2}), 64'(3'b111));
        #1 rst = 1'b1;
        #1;
        check_output("rst_async_flags", 64'({bus.busy, bus.y_valid, bus.sat, bus.s1, bus.s2}), 64'(0));
        check_output("rst_async_y", 64'(bus.y), 64'(0));
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rst = 1'b0;
            if (bus.y_valid) viol++;
        end
        check_output("rst_no_valid", 64'(viol), 64'(0));
        apply_stimulus(16'h1234, 16'h1234, 32'h0);
        run_conv("post_rst", 16'h1234, 16'h1234, 32'h0, -1, 1'b0, 16'h0, 16'h0, 32'h0);
        check_output("post_rst_const", 64'(bus.y), 64'(32'h00000040));

        $display("[TB] randomized conversions");
        pending = 1'b0;
        xa = 16'($urandom);
        xb = 16'($urandom);
        init = $urandom;
        for (int i = 0; i < 24; i++) begin
            if (!pending) begin
                for (int j = 0; j < 4; j++) begin
                    rom_tbl[j] = $urandom;
                    if ($urandom_range(0, 1) == 1)
                        rom_tbl[j] = {{11{rom_tbl[j][20]}}, rom_tbl[j][20:0]};
                end
                apply_stimulus(xa, xb, init);
            end
            nxa = 16'($urandom);
            nxb = 16'($urandom);
            ninit = $urandom;
            chain = (i < 23) && ($urandom_range(0, 1) == 1);
            run_conv("rand", xa, xb, init, -1, chain, nxa, nxb, ninit);
            pending = chain;
            xa = nxa;
            xb = nxb;
            init = ninit;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
